// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: opcode encodings, widths and
// the per-requester issue bundle.
package alu_arbiter_pkg;

    localparam int DSIZE  = 16;
    localparam int IMMW   = 4;
    localparam int NREQ   = 2;
    localparam int FLAG_W = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_RL  = 3'd7
    } alu_op_e;

    typedef struct packed {
        alu_op_e          op;
        logic [DSIZE-1:0] a;
        logic [DSIZE-1:0] b;
        logic [IMMW-1:0]  imm;
        logic             flag_en;
    } alu_req_t;

endpackage

// File: rtl/alu_arbiter_ctx.sv
// Private {n,v,z} flag context for one requester, plus the lastFlag value the
// ALU should see if this requester wins the current cycle.
module alu_arbiter_ctx
    import alu_arbiter_pkg::*;
#(
    parameter bit ID = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              resp_valid,
    input  logic              resp_id,
    input  logic [FLAG_W-1:0] alu_flag,
    output logic [FLAG_W-1:0] flag,
    output logic [FLAG_W-1:0] last_flag
);

    logic hit;
    assign hit = resp_valid && (resp_id == ID);

    always_ff @(posedge clk) begin
        if (!rst_n)
            flag <= '0;
        else if (clr)
            flag <= '0;
        else if (hit)
            flag <= alu_flag;
    end

    // A clear this cycle beats the in-flight result, which beats the stored context.
    always_comb begin
        last_flag = flag;
        if (clr)
            last_flag = '0;
        else if (hit)
            last_flag = alu_flag;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered ALU between the execute stage (req0)
// and the address/loop unit (req1), with per-requester flag contexts.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_op,
    input  logic [DSIZE-1:0]  req0_a,
    input  logic [DSIZE-1:0]  req0_b,
    input  logic [IMMW-1:0]   req0_imm,
    input  logic              req0_flag_en,
    output logic [FLAG_W-1:0] req0_flag,
    input  logic              req0_flag_clr,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_op,
    input  logic [DSIZE-1:0]  req1_a,
    input  logic [DSIZE-1:0]  req1_b,
    input  logic [IMMW-1:0]   req1_imm,
    input  logic              req1_flag_en,
    output logic [FLAG_W-1:0] req1_flag,
    input  logic              req1_flag_clr,
    output logic [DSIZE-1:0]  alu_a,
    output logic [DSIZE-1:0]  alu_b,
    output logic [2:0]        alu_op,
    output logic [IMMW-1:0]   alu_imm,
    output logic              alu_flag_en,
    output logic [FLAG_W-1:0] alu_last_flag,
    input  logic [DSIZE-1:0]  alu_out,
    input  logic [FLAG_W-1:0] alu_flag,
    output logic              resp_valid,
    output logic              resp_id,
    output logic [DSIZE-1:0]  resp_data,
    output logic [FLAG_W-1:0] resp_flag
);

    alu_req_t [NREQ-1:0]              req;
    logic     [NREQ-1:0]              valid;
    logic     [NREQ-1:0]              clr;
    logic     [NREQ-1:0][FLAG_W-1:0]  ctx_flag;
    logic     [NREQ-1:0][FLAG_W-1:0]  fwd_flag;
    logic                             rr_ptr;
    logic                             win;
    logic                             issue;

    assign req[0] = '{op: alu_op_e'(req0_op), a: req0_a, b: req0_b,
                      imm: req0_imm, flag_en: req0_flag_en};
    assign req[1] = '{op: alu_op_e'(req1_op), a: req1_a, b: req1_b,
                      imm: req1_imm, flag_en: req1_flag_en};
    assign valid  = {req1_valid, req0_valid};
    assign clr    = {req1_flag_clr, req0_flag_clr};

    // rr_ptr names the side that wins a tie; a lone requester always wins.
    assign win        = valid[1] && (!valid[0] || rr_ptr);
    assign issue      = rst_n && (|valid);
    assign req0_ready = issue && !win;
    assign req1_ready = issue && win;

    always_comb begin
        alu_op        = OP_AND;
        alu_a         = '0;
        alu_b         = '0;
        alu_imm       = '0;
        alu_flag_en   = 1'b0;
        alu_last_flag = '0;
        if (issue) begin
            alu_op        = req[win].op;
            alu_a         = req[win].a;
            alu_b         = req[win].b;
            alu_imm       = req[win].imm;
            alu_flag_en   = req[win].flag_en;
            alu_last_flag = fwd_flag[win];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr     <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
        end else begin
            resp_valid <= issue;
            if (issue) begin
                rr_ptr  <= ~win;
                resp_id <= win;
            end
        end
    end

    assign resp_data = alu_out;
    assign resp_flag = alu_flag;

    for (genvar i = 0; i < NREQ; i++) begin : g_ctx
        alu_arbiter_ctx #(.ID(i == 1)) u_ctx (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (clr[i]),
            .resp_valid (resp_valid),
            .resp_id    (resp_id),
            .alu_flag   (alu_flag),
            .flag       (ctx_flag[i]),
            .last_flag  (fwd_flag[i])
        );
    end

    assign req0_flag = ctx_flag[0];
    assign req1_flag = ctx_flag[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU plus a transaction-level
// model of grants, responses and flag contexts.
module tb_alu_arbiter;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3, SLL = 3'd5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [2:0]  req0_op = 0, req1_op = 0;
    logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [3:0]  req0_imm = 0, req1_imm = 0;
    logic        req0_flag_en = 0, req1_flag_en = 0, req0_flag_clr = 0, req1_flag_clr = 0;
    logic [2:0]  req0_flag, req1_flag;
    logic [15:0] alu_a, alu_b, alu_out, resp_data;
    logic [2:0]  alu_op, alu_last_flag, alu_flag, resp_flag;
    logic [3:0]  alu_imm;
    logic        alu_flag_en, resp_valid, resp_id;

    int nvec = 0, nerr = 0;

    // Reference state: who was granted last, committed contexts, visible response.
    int          m_last;
    logic [2:0]  m_flag [2];
    logic        m_pv;
    int          m_pid;
    logic [15:0] m_pdata;
    logic [2:0]  m_pflag;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_imm(req0_imm),
        .req0_flag_en(req0_flag_en), .req0_flag(req0_flag), .req0_flag_clr(req0_flag_clr),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_imm(req1_imm),
        .req1_flag_en(req1_flag_en), .req1_flag(req1_flag), .req1_flag_clr(req1_flag_clr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_imm(alu_imm),
        .alu_flag_en(alu_flag_en), .alu_last_flag(alu_last_flag),
        .alu_out(alu_out), .alu_flag(alu_flag),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_flag(resp_flag)
    );

    // Behavioural ALU: signed overflow suppresses n and z.
    function automatic logic [18:0] alu_calc(input logic [2:0] op, input logic [15:0] a, b,
                                             input logic [3:0] imm, input logic fe, input logic [2:0] lf);
        logic [15:0] r;
        logic        v;
        logic [2:0]  f;
        v = 1'b0;
        case (op)
            3'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
            3'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << imm;
            3'd6: r = a >> imm;
            default: r = (a << imm) | (a >> (5'd16 - {1'b0, imm}));
        endcase
        f = (fe && op < 3'd4) ? {r[15] && !v, v, (r == 16'd0) && !v} : lf;
        return {r, f};
    endfunction

    always_ff @(posedge clk)
        {alu_out, alu_flag} <= alu_calc(alu_op, alu_a, alu_b, alu_imm, alu_flag_en, alu_last_flag);

    function automatic int pick();
        if (!rst_n) return -1;
        if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic logic [2:0] exp_last(input int w);
        logic c;
        c = (w == 0) ? req0_flag_clr : req1_flag_clr;
        if (c) return 3'b000;
        if (m_pv && m_pid == w) return m_pflag;
        return m_flag[w];
    endfunction

    // Advance one clock and the reference model; ends at the falling edge.
    task automatic tick();
        int w;
        logic [18:0] r;
        logic c0, c1;
        w = pick();
        c0 = req0_flag_clr;
        c1 = req1_flag_clr;
        r = '0;
        if (w == 0) r = alu_calc(req0_op, req0_a, req0_b, req0_imm, req0_flag_en, exp_last(0));
        if (w == 1) r = alu_calc(req1_op, req1_a, req1_b, req1_imm, req1_flag_en, exp_last(1));
        @(posedge clk);
        if (!rst_n) begin
            m_last = 1; m_flag[0] = 3'b000; m_flag[1] = 3'b000; m_pv = 1'b0; m_pid = 0;
        end else begin
            if (m_pv) m_flag[m_pid] = m_pflag;
            if (c0) m_flag[0] = 3'b000;
            if (c1) m_flag[1] = 3'b000;
            m_pv = (w >= 0);
            if (w >= 0) begin
                m_pid = w; m_last = w; m_pdata = r[18:3]; m_pflag = r[2:0];
            end
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int id, input logic v, input logic [2:0] op,
                           input logic [15:0] a, b, input logic [3:0] imm, input logic fe);
        if (id == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_imm = imm; req0_flag_en = fe;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_imm = imm; req1_flag_en = fe;
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        set_req(0, 1, ADD, 16'($urandom), 16'($urandom), 4'($urandom), 1);
        set_req(1, 1, SUB, 16'($urandom), 16'($urandom), 4'($urandom), 1);
        #1;
        nvec++; if ({req0_ready, req1_ready} !== 2'b00) begin nerr++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
        tick(); tick();
        nvec++; if (resp_valid !== 1'b0 || resp_id !== 1'b0) begin nerr++; $display("FAIL reset_resp: got %b%b want 00", resp_valid, resp_id); end
        rst_n = 1; req0_valid = 0; req1_valid = 0;
        #1; tick();
        nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL post_reset_valid: got %b want 0", resp_valid); end
        nvec++; if ({req0_flag, req1_flag} !== 6'b0) begin nerr++; $display("FAIL reset_flags: got %b_%b want 000_000", req0_flag, req1_flag); end
    endtask

    task automatic test_contention();
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));
            set_req(1, 1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));
            #1;
            nvec++; if ({req1_ready, req0_ready} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                nerr++; $display("FAIL contention_grant[%0d]: got r1r0=%b%b", k, req1_ready, req0_ready); end
            tick();
            nvec++; if (resp_valid !== 1'b1 || resp_id !== 1'(k % 2)) begin
                nerr++; $display("FAIL contention_resp[%0d]: got v=%b id=%b want v=1 id=%0d", k, resp_valid, resp_id, k % 2); end
        end
        req0_valid = 0; req1_valid = 0;
        #1; tick();
    endtask

    task automatic test_single();
        set_req(0, 1, ADD, 16'h7FFF, 16'h0001, 4'd0, 1);
        #1;
        nvec++; if ({req0_ready, req1_ready} !== 2'b10) begin nerr++; $display("FAIL single_grant: got %b%b want 10", req0_ready, req1_ready); end
        tick();
        req0_valid = 0;
        nvec++; if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== 16'h8000 || resp_flag !== 3'b010) begin
            nerr++; $display("FAIL single_resp: got v=%b id=%b d=%h f=%b want v=1 id=0 d=8000 f=010", resp_valid, resp_id, resp_data, resp_flag); end
        #1; tick();
        nvec++; if (req0_flag !== 3'b010) begin nerr++; $display("FAIL single_ctx: got %b want 010", req0_flag); end
    endtask

    task automatic test_forwarding();
        set_req(0, 1, SUB, 16'd5, 16'd5, 4'd0, 1);
        #1; tick();
        set_req(0, 1, SLL, 16'h0003, 16'h0000, 4'd2, 0);
        #1;
        nvec++; if (alu_last_flag !== 3'b001) begin nerr++; $display("FAIL fwd_last_flag: got %b want 001", alu_last_flag); end
        tick();
        req0_valid = 0;
        nvec++; if (resp_flag !== 3'b001 || resp_data !== 16'h000C) begin nerr++; $display("FAIL fwd_resp: got d=%h f=%b want d=000c f=001", resp_data, resp_flag); end
        #1; tick();
        nvec++; if (req0_flag !== 3'b001) begin nerr++; $display("FAIL fwd_ctx: got %b want 001", req0_flag); end
    endtask

    task automatic test_isolation();
        set_req(1, 1, ADD, 16'h8000, 16'h8000, 4'd0, 1);
        #1; tick();
        req1_valid = 0;
        set_req(0, 1, OR_, 16'h0000, 16'h0000, 4'd0, 1);
        #1; tick();
        req0_valid = 0;
        #1; tick(); tick();
        nvec++; if (req0_flag !== 3'b001 || req1_flag !== 3'b010) begin
            nerr++; $display("FAIL isolation: got f0=%b f1=%b want 001 010", req0_flag, req1_flag); end
    endtask

    task automatic test_clear();
        set_req(1, 1, ADD, 16'h8000, 16'h8000, 4'd0, 1);
        #1; tick();
        // Response 010 for req1 is visible now; clear and reissue in the same cycle.
        set_req(1, 1, SLL, 16'h0001, 16'h0000, 4'd1, 0);
        req1_flag_clr = 1;
        #1;
        nvec++; if (alu_last_flag !== 3'b000) begin nerr++; $display("FAIL clr_last_flag: got %b want 000", alu_last_flag); end
        tick();
        req1_flag_clr = 0; req1_valid = 0;
        nvec++; if (req1_flag !== 3'b000 || resp_flag !== 3'b000) begin
            nerr++; $display("FAIL clr_collision: got ctx=%b resp=%b want 000 000", req1_flag, resp_flag); end
        #1; tick();
        nvec++; if (req1_flag !== 3'b000) begin nerr++; $display("FAIL clr_ctx: got %b want 000", req1_flag); end
        // Reset while a response is on the bus, with a fresh request during reset.
        set_req(0, 1, ADD, 16'h7FFF, 16'h0001, 4'd0, 1);
        #1; tick();
        rst_n = 0;
        #1;
        nvec++; if (req0_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready: got %b want 0", req0_ready); end
        tick();
        nvec++; if (resp_valid !== 1'b0 || req0_flag !== 3'b000) begin
            nerr++; $display("FAIL rst_midflight: got v=%b f0=%b want 0 000", resp_valid, req0_flag); end
        rst_n = 1; req0_valid = 0;
        #1; tick();
        nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL rst_issue_dropped: got %b want 0", resp_valid); end
    endtask

    task automatic test_random();
        int w;
        for (int k = 0; k < 400; k++) begin
            set_req(0, 1'($urandom_range(0, 9) < 6), 3'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));
            set_req(1, 1'($urandom_range(0, 9) < 6), 3'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));
            req0_flag_clr = ($urandom_range(0, 7) == 0);
            req1_flag_clr = ($urandom_range(0, 7) == 0);
            #1;
            w = pick();
            nvec++; if ({req0_ready, req1_ready} !== {1'(w == 0), 1'(w == 1)}) begin
                nerr++; $display("FAIL rnd_grant[%0d]: got %b%b want winner %0d", k, req0_ready, req1_ready, w); end
            if (w >= 0) begin
                nvec++; if (alu_last_flag !== exp_last(w)) begin
                    nerr++; $display("FAIL rnd_last_flag[%0d]: got %b want %b", k, alu_last_flag, exp_last(w)); end
            end else begin
                nvec++; if (alu_op !== AND_ || alu_flag_en !== 1'b0 || alu_a !== 16'd0 || alu_b !== 16'd0) begin
                    nerr++; $display("FAIL rnd_idle[%0d]: got op=%0d fe=%b a=%h b=%h", k, alu_op, alu_flag_en, alu_a, alu_b); end
            end
            tick();
            nvec++; if (resp_valid !== m_pv) begin nerr++; $display("FAIL rnd_resp_valid[%0d]: got %b want %b", k, resp_valid, m_pv); end
            if (m_pv) begin
                nvec++; if (resp_id !== 1'(m_pid) || resp_data !== m_pdata || resp_flag !== m_pflag) begin
                    nerr++; $display("FAIL rnd_resp[%0d]: got id=%b d=%h f=%b want id=%0d d=%h f=%b",
                                     k, resp_id, resp_data, resp_flag, m_pid, m_pdata, m_pflag); end
            end
            nvec++; if (req0_flag !== m_flag[0] || req1_flag !== m_flag[1]) begin
                nerr++; $display("FAIL rnd_ctx[%0d]: got %b_%b want %b_%b", k, req0_flag, req1_flag, m_flag[0], m_flag[1]); end
        end
        req0_valid = 0; req1_valid = 0; req0_flag_clr = 0; req1_flag_clr = 0;
    endtask

    initial begin
        m_last = 1; m_flag[0] = 0; m_flag[1] = 0; m_pv = 0; m_pid = 0; m_pdata = 0; m_pflag = 0;
        @(negedge clk);
        test_reset();
        test_contention();
        test_single();
        test_forwarding();
        test_isolation();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
